clint_timer: RTL
================

Name: clint_timer

Overview:
- Core-local interruptor: memory-mapped responder holding mtime, mtimecmp and msip.
- Drives the timer interrupt (trint) and software interrupt (swint) inputs of the machine-mode CSR block.
- Sits on the uncached data-bus path, decoded by address from the memory stage, single hart.

Parameters:
BASE_ADDR, 64'h0000_0000_0200_0000, base of CLINT window
TICK_DIV, 1, core cycles per mtime increment (>=1)

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
req_valid  in  1  bus request valid, held until resp_ok
req_write  in  1  1 = store, 0 = load
req_addr  in  64  byte address; bits [2:0] ignored (8-byte aligned access)
req_strobe  in  8  byte-enables for stores
req_wdata  in  64  store data
resp_ok  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_ok; 1 = unmapped address
resp_rdata  out  64  load data, valid with resp_ok
trint  out  1  timer interrupt pending
swint  out  1  software interrupt pending
mtime_o  out  64  current mtime, for CSR time/mcycle compare

Behaviour:
- Reset (synchronous, on clk edge with reset=1): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, divider=0, FSM=IDLE, resp_ok=0, resp_err=0, resp_rdata=0. Consequently trint=0 and swint=0 out of reset.
- Register map (offset = {req_addr[63:3],3'b0} - BASE_ADDR):
  - 0x0000 msip: bit0 writable, bits 63:1 read 0.
  - 0x4000 mtimecmp: 64-bit R/W.
  - 0xBFF8 mtime: 64-bit R/W.
  - Any other offset is unmapped.
- FSM: IDLE, RESP.
  - IDLE & req_valid: decode the request, perform the access at this clk edge, latch rdata/err, go to RESP.
  - RESP: resp_ok=1 for exactly this cycle, then return to IDLE.
  - A request is never accepted while in RESP; a request held high re-accepts in the following IDLE cycle.
  - Latency: accept cycle N -> resp_ok in cycle N+1.
- Loads return the value sampled at the accept edge. For mtime, that is the value before that edge's increment.
- Stores are byte-masked per req_strobe. Strobe=0 completes normally with no change.
- Unmapped access: resp_err=1, resp_rdata=0, no state change.
- mtime tick:
  - Divider counts 0..TICK_DIV-1; mtime increments by 1 on the edge where divider==TICK_DIV-1, and the divider returns to 0.
  - TICK_DIV=1 means an increment every cycle.
  - Wrap: 64'hFFFF_FFFF_FFFF_FFFF -> 0, no flag.
- Simultaneous store to mtime and tick: the store wins (mtime = merged write value, no +1). The divider is not reset.
- trint = (mtime >= mtimecmp), unsigned, combinational from registers. It updates the cycle after any mtime/mtimecmp change and is level, not pulse.
- swint = msip[0], registered.
- mtime_o = mtime register.
- Reset asserted mid-transaction: FSM returns to IDLE, no resp_ok is issued, and the requester must reissue.

Optional Feature:
CLINT_MTIME_WRITE_EN
- Defined: mtime is writable as above.
- Undefined: stores to offset 0xBFF8 complete with resp_ok=1, resp_err=0 and no effect, and mtime increments normally. Loads are unaffected.

Test Plan:
- Reset, TICK_DIV=1, idle 10 cycles -> mtime_o=10, trint=0, swint=0, resp_ok never asserted.
- Store mtimecmp=0x20 with strobe 8'hFF; load mtimecmp -> resp_ok one cycle after each accept, rdata=0x20. trint rises the cycle after mtime reaches 0x20 and stays high. Then store mtimecmp=0xFFFF_FFFF_FFFF_FFFF -> trint=0 the next cycle.
- Store msip=1 -> swint=1 the cycle after accept. Store msip=0xFFFF_FFFF_FFFF_FFFE -> swint=0, and a load reads 0.
- With CLINT_MTIME_WRITE_EN defined: store mtime=0xFFFF_FFFF_FFFF_FFFE on a tick edge -> mtime=...FE (write wins), then FF, then 0. Without the macro: the same store leaves mtime counting from its prior value, with resp_err=0.
- Load from BASE+0x1000 -> resp_ok=1, resp_err=1, rdata=0. Byte store strobe=8'h01, data 0xAB to mtimecmp=0x1234 -> mtimecmp=0x12AB.
- TICK_DIV=4, request held continuously, reset pulsed in the RESP-pending cycle -> no resp_ok, registers at reset values, request re-accepted after reset deasserts, and mtime steps once per 4 cycles.

Source files
------------

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
// Core-local interruptor for a single hart. A memory-mapped responder on the
// uncached data-bus path that holds mtime, mtimecmp and msip, and drives the
// timer (trint) and software (swint) interrupt lines of the machine-mode CSRs.
//
// Register map (offset from BASE_ADDR, 8-byte aligned, addr[2:0] ignored):
//   0x0000  msip      bit0 R/W, bits 63:1 read as 0
//   0x4000  mtimecmp  64-bit R/W
//   0xBFF8  mtime     64-bit R/W (write only when CLINT_MTIME_WRITE_EN is defined)
//   other   unmapped  -> resp_err=1, resp_rdata=0, no state change
//
// Build option:
//   CLINT_MTIME_WRITE_EN  defined   : stores to mtime take effect.
//                         undefined : stores to mtime complete without error
//                                     and have no effect.
//
// Parameters:
//   BASE_ADDR  base of the CLINT window
//   TICK_DIV   core cycles per mtime increment (>= 1)
//
// Ports:
//   clk, reset     core clock, synchronous active-high reset
//   req_*          bus request; req_valid is held by the requester until resp_ok
//   resp_ok        one-cycle completion pulse, the cycle after acceptance
//   resp_err       valid with resp_ok, 1 = unmapped address
//   resp_rdata     load data, valid with resp_ok
//   trint          timer interrupt pending (mtime >= mtimecmp, unsigned)
//   swint          software interrupt pending (msip[0])
//   mtime_o        current mtime register
//   dbg_fsm_state  current bus FSM state (0 = IDLE, 1 = RESP)
//
// Handshake: a request is accepted on a rising edge where the FSM is IDLE and
// req_valid=1. The access (load sample or store) happens on that same edge and
// resp_ok is high for exactly the following cycle. No request is accepted in
// the RESP cycle, so a requester that keeps req_valid high after resp_ok is
// accepted again in the next IDLE cycle. A reset during a pending transaction
// drops it without any resp_ok; the requester must reissue.
// -----------------------------------------------------------------------------
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_wdata,
    output logic        resp_ok,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic        trint,
    output logic        swint,
    output logic [63:0] mtime_o,
    output logic        dbg_fsm_state
);

    localparam logic [63:0] OFF_MSIP     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] OFF_MTIMECMP = 64'h0000_0000_0000_4000;
    localparam logic [63:0] OFF_MTIME    = 64'h0000_0000_0000_BFF8;

    // Divider is at least one bit wide so TICK_DIV=1 still elaborates; in that
    // case it simply stays at 0 and every edge is a tick.
    localparam int unsigned       DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_resp_ok;

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_msip;
    logic [DIV_W-1:0]   r_div;
    logic               r_resp_err;
    logic [63:0]        r_resp_rdata;

    logic [63:0]        w_offset;
    logic               w_hit_msip;
    logic               w_hit_mtimecmp;
    logic               w_hit_mtime;
    logic               w_mapped;
    logic [63:0]        w_mask;
    logic [63:0]        w_mtimecmp_merged;
    logic               w_msip_next;
    logic               w_wr_msip;
    logic               w_wr_mtimecmp;
    logic               w_tick;
    logic [63:0]        w_rdata;
    logic               w_unused_addr_lsb;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_offset          = {req_addr[63:3], 3'b000} - BASE_ADDR;
    assign w_hit_msip        = (w_offset == OFF_MSIP);
    assign w_hit_mtimecmp    = (w_offset == OFF_MTIMECMP);
    assign w_hit_mtime       = (w_offset == OFF_MTIME);
    assign w_mapped          = w_hit_msip | w_hit_mtimecmp | w_hit_mtime;
    assign w_unused_addr_lsb = ^req_addr[2:0];

    // ------------------------------------------------------------------
    // Bus FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_resp_ok    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_ok    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Store data merge: expand byte strobes into a bit mask
    // ------------------------------------------------------------------
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < 8; b++) begin
            w_mask[b*8 +: 8] = {8{req_strobe[b]}};
        end
    end

    assign w_mtimecmp_merged = (r_mtimecmp & ~w_mask) | (req_wdata & w_mask);
    // Only bit 0 of msip exists, so only byte lane 0 can change it.
    assign w_msip_next       = req_strobe[0] ? req_wdata[0] : r_msip;

    assign w_wr_msip     = w_accept & req_write & w_hit_msip;
    assign w_wr_mtimecmp = w_accept & req_write & w_hit_mtimecmp;

    // ------------------------------------------------------------------
    // Load data mux (value before this edge's updates)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (!req_write) begin
            if (w_hit_msip) begin
                w_rdata = {63'd0, r_msip};
            end else if (w_hit_mtimecmp) begin
                w_rdata = r_mtimecmp;
            end else if (w_hit_mtime) begin
                w_rdata = r_mtime;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // mtime: a store on a tick edge wins over the increment; the divider
    // keeps running either way.
    // ------------------------------------------------------------------
`ifdef CLINT_MTIME_WRITE_EN
    logic        w_wr_mtime;
    logic [63:0] w_mtime_merged;

    assign w_wr_mtime     = w_accept & req_write & w_hit_mtime;
    assign w_mtime_merged = (r_mtime & ~w_mask) | (req_wdata & w_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime <= '0;
        end else if (w_wr_mtime) begin
            r_mtime <= w_mtime_merged;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end
`else
    // Stores to mtime are acknowledged by the FSM but never reach the register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime <= '0;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // mtimecmp, msip and the latched response
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtimecmp   <= '1;
            r_msip       <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            if (w_wr_mtimecmp) begin
                r_mtimecmp <= w_mtimecmp_merged;
            end
            if (w_wr_msip) begin
                r_msip <= w_msip_next;
            end
            if (w_accept) begin
                r_resp_err   <= ~w_mapped;
                r_resp_rdata <= w_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign resp_ok       = w_resp_ok;
    assign resp_err      = r_resp_err;
    assign resp_rdata    = r_resp_rdata;
    assign trint         = (r_mtime >= r_mtimecmp);
    assign swint         = r_msip;
    assign mtime_o       = r_mtime;
    assign dbg_fsm_state = r_state;

endmodule
